// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: CPU-side and RAM-side bus bundles for the memory bridge
interface cpu_bus_if;
    logic        cpu_valid;
    logic        cpu_rw;
    logic [31:0] cpu_address;
    logic [31:0] cpu_datao;
    logic [31:0] cpu_data;
    logic        cpu_ready;
    logic        bus_error;
    modport master (output cpu_valid, cpu_rw, cpu_address, cpu_datao,
                    input  cpu_data, cpu_ready, bus_error);
    modport slave  (input  cpu_valid, cpu_rw, cpu_address, cpu_datao,
                    output cpu_data, cpu_ready, bus_error);
endinterface

interface ram_bus_if #(parameter int MEM_AW = 16);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: routes CPU requests to timed-out RAM handshake or internal IO registers
module mem_bus_bridge #(
    parameter int          MEM_AW  = 16,
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
    parameter int          TIMEOUT = 15
) (
    input  logic        clock_i,
    input  logic        reset_i,
    cpu_bus_if.slave    cpu,
    ram_bus_if.master   ram,
    output logic [31:0] io_out_o
);
    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
    state_t            state_q, state_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       io_q, io_d;
    logic [4:0]        tmo_q, tmo_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [31:0]       off;
    logic [31:0]       io_rd;
    assign off   = cpu.cpu_address - IO_BASE;
    assign io_rd = off == 32'd0 ? io_q : off == 32'd1 ? cyc_q : 32'd0;
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        io_d    = io_q;
        tmo_d   = tmo_q;
        cyc_d   = cyc_q + 32'd1;
        case (state_q)
            IDLE: if (cpu.cpu_valid) begin
                if (cpu.cpu_address >= IO_BASE) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    data_d  = cpu.cpu_rw ? io_rd : 32'd0;
                    if (!cpu.cpu_rw && off == 32'd0) io_d = cpu.cpu_datao;
                end else begin
                    state_d = MEM;
                    req_d   = 1'b1;
                    we_d    = ~cpu.cpu_rw;
                    addr_d  = cpu.cpu_address[MEM_AW-1:0];
                    wdata_d = cpu.cpu_datao;
                    tmo_d   = 5'd0;
                end
            end
            MEM: if (ram.mem_ack) begin
                state_d = RESP;
                req_d   = 1'b0;
                we_d    = 1'b0;
                data_d  = we_q ? 32'd0 : ram.mem_rdata;
                err_d   = 1'b0;
            end else if (tmo_q == 5'(TIMEOUT - 1)) begin
                // ack takes priority over the timeout on the final cycle
                state_d = RESP;
                req_d   = 1'b0;
                data_d  = 32'hDEAD_BEEF;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 5'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            io_q    <= '0;
            tmo_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            io_q    <= io_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
        end
    end
    assign cpu.cpu_data  = data_q;
    assign cpu.cpu_ready = state_q == RESP;
    assign cpu.bus_error = err_q;
    assign ram.mem_req   = req_q;
    assign ram.mem_we    = we_q;
    assign ram.mem_addr  = addr_q;
    assign ram.mem_wdata = wdata_q;
    assign io_out_o      = io_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed self-checking bench for mem_bus_bridge
module tb_mem_bus_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_out;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_cyc, lat;
    logic [31:0] c1, c2;
    cpu_bus_if            cpu();
    ram_bus_if #(.MEM_AW(16)) ram();
    mem_bus_bridge #(.MEM_AW(16), .IO_BASE(32'hFFFF_0000), .TIMEOUT(15)) dut (
        .clock_i(clk),
        .reset_i(rst),
        .cpu(cpu.slave),
        .ram(ram.master),
        .io_out_o(io_out)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        cpu.cpu_valid = 1'b1;
        cpu.cpu_rw = rw;
        cpu.cpu_address = addr;
        cpu.cpu_datao = data;
        @(negedge clk);
        cpu.cpu_valid = 1'b0;
        cpu.cpu_datao = 32'h0;
    endtask
    // k < 0 holds ack low; otherwise ack is driven in the (k+1)-th cycle with mem_req high
    task automatic ram_run(input int k, input logic [31:0] rd, output int rc, output int lt);
        rc = 0;
        lt = 0;
        for (int i = 1; i <= 40 && lt == 0; i++) begin
            if (ram.mem_req) rc++;
            if (cpu.cpu_ready) lt = i;
            else begin
                ram.mem_ack = k >= 0 && ram.mem_req && rc == k + 1;
                ram.mem_rdata = ram.mem_ack ? rd : 32'hBAD0_0000;
                @(negedge clk);
            end
        end
        ram.mem_ack = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        cpu.cpu_valid = 1'b0;
        cpu.cpu_rw = 1'b0;
        cpu.cpu_address = 32'h0;
        cpu.cpu_datao = 32'h0;
        ram.mem_ack = 1'b0;
        ram.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cpu.cpu_ready), 32'd0);
        chk("rst_req", 32'(ram.mem_req), 32'd0);
        chk("rst_io", io_out, 32'd0);
        chk("rst_data", cpu.cpu_data, 32'd0);
        chk("rst_err", 32'(cpu.bus_error), 32'd0);
        rst = 1'b0;
        issue(1'b0, 32'hFFFF_0000, 32'h0000_00A5);
        chk("iow_ready", 32'(cpu.cpu_ready), 32'd1);
        chk("iow_io", io_out, 32'hA5);
        chk("iow_err", 32'(cpu.bus_error), 32'd0);
        issue(1'b1, 32'hFFFF_0000, 32'h0);
        chk("ior_ready", 32'(cpu.cpu_ready), 32'd1);
        chk("ior_data", cpu.cpu_data, 32'hA5);
        @(negedge clk);
        chk("ior_pulse", 32'(cpu.cpu_ready), 32'd0);
        issue(1'b1, 32'h0000_0010, 32'h0);
        chk("rd_addr", 32'(ram.mem_addr), 32'h0010);
        chk("rd_we", 32'(ram.mem_we), 32'd0);
        ram_run(3, 32'h1234_5678, req_cyc, lat);
        chk("rd_reqcyc", 32'(req_cyc), 32'd4);
        chk("rd_lat", 32'(lat), 32'd5);
        chk("rd_data", cpu.cpu_data, 32'h1234_5678);
        chk("rd_err", 32'(cpu.bus_error), 32'd0);
        @(negedge clk);
        chk("rd_pulse", 32'(cpu.cpu_ready), 32'd0);
        issue(1'b0, 32'h0000_0020, 32'h0000_CAFE);
        chk("wr_we", 32'(ram.mem_we), 32'd1);
        chk("wr_wdata", ram.mem_wdata, 32'hCAFE);
        chk("wr_addr", 32'(ram.mem_addr), 32'h0020);
        ram_run(0, 32'h5555_5555, req_cyc, lat);
        chk("wr_reqcyc", 32'(req_cyc), 32'd1);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_data", cpu.cpu_data, 32'd0);
        issue(1'b1, 32'h0000_0030, 32'h0);
        ram_run(-1, 32'h0, req_cyc, lat);
        chk("to_reqcyc", 32'(req_cyc), 32'd15);
        chk("to_lat", 32'(lat), 32'd16);
        chk("to_err", 32'(cpu.bus_error), 32'd1);
        chk("to_data", cpu.cpu_data, 32'hDEAD_BEEF);
        @(negedge clk);
        ram.mem_ack = 1'b1;
        ram.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        ram.mem_ack = 1'b0;
        chk("late_ready", 32'(cpu.cpu_ready), 32'd0);
        chk("late_req", 32'(ram.mem_req), 32'd0);
        chk("late_data", cpu.cpu_data, 32'hDEAD_BEEF);
        chk("late_err", 32'(cpu.bus_error), 32'd1);
        issue(1'b1, 32'h0000_0040, 32'h0);
        ram_run(14, 32'h0BAD_F00D, req_cyc, lat);
        chk("last_reqcyc", 32'(req_cyc), 32'd15);
        chk("last_lat", 32'(lat), 32'd16);
        chk("last_err", 32'(cpu.bus_error), 32'd0);
        chk("last_data", cpu.cpu_data, 32'h0BAD_F00D);
        issue(1'b1, 32'hFFFF_0001, 32'h0);
        c1 = cpu.cpu_data;
        repeat (8) @(negedge clk);
        issue(1'b1, 32'hFFFF_0001, 32'h0);
        c2 = cpu.cpu_data;
        chk("cyc_delta", c2 - c1, 32'd10);
        issue(1'b0, 32'hFFFF_0001, 32'h0);
        chk("cyc_wr_err", 32'(cpu.bus_error), 32'd0);
        issue(1'b1, 32'hFFFF_0001, 32'h0);
        chk("cyc_after_wr", cpu.cpu_data - c2, 32'd4);
        issue(1'b1, 32'hFFFF_0007, 32'h0);
        chk("io_off7", cpu.cpu_data, 32'd0);
        issue(1'b1, 32'h0000_0050, 32'h0);
        @(negedge clk);
        chk("mid_req", 32'(ram.mem_req), 32'd1);
        rst = 1'b1;
        ram.mem_ack = 1'b1;
        ram.mem_rdata = 32'h4444_4444;
        @(negedge clk);
        ram.mem_ack = 1'b0;
        chk("mid_req_drop", 32'(ram.mem_req), 32'd0);
        chk("mid_ready", 32'(cpu.cpu_ready), 32'd0);
        chk("mid_io", io_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready2", 32'(cpu.cpu_ready), 32'd0);
        issue(1'b1, 32'h0000_0060, 32'h0);
        ram_run(1, 32'h8765_4321, req_cyc, lat);
        chk("post_lat", 32'(lat), 32'd3);
        chk("post_data", cpu.cpu_data, 32'h8765_4321);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
